// File: rtl/priority_code_stream_decoder.sv
// Priority code stream decoder.
// Rebuilds a word from a stream of priority-encoded bit indices, highest first.
// Each beat is decoded to one-hot and ORed into an accumulating mask. The last
// beat of a word releases the rebuilt word on a valid/ready output port. Beats
// that break the strictly-descending order are still merged, but they raise
// order_err for that word.
module priority_code_stream_decoder #(
  parameter int CODE_W = 3,
  localparam int DATA_W = 2**CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code,
  input  logic              code_none,
  input  logic              code_last,
  output logic [DATA_W-1:0] onehot,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data,
  output logic              order_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mask;
  logic [CODE_W-1:0] prev;
  logic              err_acc;

  logic              accept;
  logic [DATA_W-1:0] beat_oh;
  logic [DATA_W-1:0] mask_next;
  logic              beat_err;

  // An all-zero beat contributes nothing to the mask.
  function automatic logic [DATA_W-1:0] decode_code(input logic [CODE_W-1:0] c,
                                                    input logic              none);
    logic [DATA_W-1:0] oh;
    oh = '0;
    if (!none) oh[c] = 1'b1;
    return oh;
  endfunction

  // Codes after the first beat must strictly descend. An empty-word beat is
  // only legal as the sole, final beat of its word.
  function automatic logic order_violation(input state_t            st,
                                           input logic [CODE_W-1:0] c,
                                           input logic [CODE_W-1:0] p,
                                           input logic              none,
                                           input logic              last);
    logic bad;
    bad = 1'b0;
    if (st == ACCUM && (none || c >= p)) bad = 1'b1;
    if (none && !last) bad = 1'b1;
    return bad;
  endfunction

  // Combinational view of the beat being offered this cycle.
  always_comb begin
    accept    = code_valid & code_ready;
    beat_oh   = decode_code(code, code_none);
    mask_next = mask | beat_oh;
    beat_err  = order_violation(state, code, prev, code_none, code_last);
  end

  // Word assembly FSM. All outputs are registered. code_ready is low only
  // while a word sits on the output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask       <= '0;
      prev       <= '0;
      err_acc    <= 1'b0;
      onehot     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      order_err  <= 1'b0;
      code_ready <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            onehot <= beat_oh;
            prev   <= code;
            if (code_last) begin
              data       <= mask_next;
              order_err  <= err_acc | beat_err;
              data_valid <= 1'b1;
              mask       <= '0;
              err_acc    <= 1'b0;
              code_ready <= 1'b0;
              state      <= OUT;
            end else begin
              mask    <= mask_next;
              err_acc <= err_acc | beat_err;
              state   <= ACCUM;
            end
          end
        end
        OUT: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            code_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          data_valid <= 1'b0;
          code_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_code_stream_decoder.sv
// Testbench for priority_code_stream_decoder.
// The driver issues words beat by beat and queues the expected word. A monitor
// process pops the queue and compares on every output handshake.
module tb_priority_code_stream_decoder;

  localparam int CODE_W = 3;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              code_valid = 1'b0;
  logic              code_ready;
  logic [CODE_W-1:0] code = '0;
  logic              code_none = 1'b0;
  logic              code_last = 1'b0;
  logic [DATA_W-1:0] onehot;
  logic              data_valid;
  logic              data_ready = 1'b1;
  logic [DATA_W-1:0] data;
  logic              order_err;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  logic [DATA_W-1:0] exp_data_q[$];
  logic              exp_err_q[$];

  logic [CODE_W-1:0] bcode[16];
  logic              bnone[16];
  int                bn;

  priority_code_stream_decoder #(.CODE_W(CODE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code       (code),
    .code_none  (code_none),
    .code_last  (code_last),
    .onehot     (onehot),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .order_err  (order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the word is the set of indices named by non-empty beats; the
  // word is flagged if any beat after the first fails to drop below its
  // predecessor, if an empty beat follows another beat, or if an empty beat
  // is not the final one.
  task automatic model_push();
    logic [DATA_W-1:0] w;
    logic              e;
    w = '0;
    e = 1'b0;
    for (int i = 0; i < bn; i++) begin
      if (!bnone[i]) w[bcode[i]] = 1'b1;
      if (i > 0 && (bnone[i] || bcode[i] >= bcode[i-1])) e = 1'b1;
      if (bnone[i] && i != bn - 1) e = 1'b1;
    end
    exp_data_q.push_back(w);
    exp_err_q.push_back(e);
  endtask

  // Drives bcode/bnone[0..bn-1]; called at posedge+1. When is_word is set the
  // final beat carries code_last and the expected word is queued.
  task automatic send_beats(input bit is_word, input int max_gap);
    logic [DATA_W-1:0] eo;
    bit ok;
    int waited;
    int gap;
    if (is_word) model_push();
    for (int i = 0; i < bn; i++) begin
      if (max_gap > 0) begin
        code_valid = 1'b0;
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin @(posedge clk); #1; end
      end
      code_valid = 1'b1;
      code       = bcode[i];
      code_none  = bnone[i];
      code_last  = is_word && (i == bn - 1);
      ok = 1'b0;
      waited = 0;
      while (!ok && waited <= 200) begin
        @(negedge clk);
        if (code_ready) ok = 1'b1;
        else waited++;
      end
      if (!ok) begin
        check("beat_accept_timeout", 32'd0, 32'd1);
        code_valid = 1'b0;
        code_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      eo = '0;
      if (!bnone[i]) eo[bcode[i]] = 1'b1;
      check("onehot", onehot, eo);
      if (code_last) check("valid_after_last", data_valid, 1);
    end
    code_valid = 1'b0;
    code_last  = 1'b0;
    code_none  = 1'b0;
  endtask

  task automatic set1(input int c0);
    bn = 1; bcode[0] = 3'(c0); bnone[0] = 1'b0;
  endtask

  task automatic set2(input int c0, input int c1);
    bn = 2; bcode[0] = 3'(c0); bcode[1] = 3'(c1); bnone[0] = 1'b0; bnone[1] = 1'b0;
  endtask

  // Consumer-side ready generator, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       data_ready = 1'b1;
        2:       data_ready = 1'b0;
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each handshaken word against the scoreboard and checks
  // that a stalled word stays put.
  logic              hold = 1'b0;
  logic [DATA_W-1:0] hd;
  logic              he;
  logic [DATA_W-1:0] ed;
  logic              ee;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        check("ready_vs_valid", code_ready, !data_valid);
        if (hold) begin
          check("hold_valid", data_valid, 1);
          check("hold_data", data, hd);
          check("hold_err", order_err, he);
        end
        hold = data_valid && !data_ready;
        hd   = data;
        he   = order_err;
        if (data_valid && data_ready) begin
          if (exp_data_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
          end else begin
            ed = exp_data_q.pop_front();
            ee = exp_err_q.pop_front();
            check("data", data, ed);
            check("order_err", order_err, ee);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int waited;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_valid", data_valid, 0);
    check("rst_data", data, 0);
    check("rst_onehot", onehot, 0);
    check("rst_order_err", order_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_code_ready", code_ready, 1);

    // Two-beat clean word, then single-beat words
    set2(2, 0); send_beats(1, 0);
    set1(6); send_beats(1, 0);
    set1(7); send_beats(1, 0);

    // Full word, then an empty word
    bn = 8;
    for (int i = 0; i < 8; i++) begin bcode[i] = 3'(7 - i); bnone[i] = 1'b0; end
    send_beats(1, 0);
    bn = 1; bcode[0] = 3'd3; bnone[0] = 1'b1; send_beats(1, 0);

    // Order errors, then a clean word
    set2(3, 5); send_beats(1, 0);
    bn = 6;
    bcode[0] = 3'd6; bcode[1] = 3'd5; bcode[2] = 3'd5;
    bcode[3] = 3'd4; bcode[4] = 3'd1; bcode[5] = 3'd0;
    for (int i = 0; i < 6; i++) bnone[i] = 1'b0;
    send_beats(1, 0);
    set1(0); send_beats(1, 0);

    // Backpressure
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    set2(2, 0); send_beats(1, 0);
    code_valid = 1'b1; code = 3'd5; code_none = 1'b0; code_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_code_ready", code_ready, 0);
      check("bp_data_valid", data_valid, 1);
      check("bp_data", data, 8'h05);
    end
    @(posedge clk); #1;
    check("bp_onehot_unchanged", onehot, 8'h01);
    code_valid = 1'b0; code_last = 1'b0;
    @(negedge clk);
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk); #1;
    check("bp_release_ready", code_ready, 1);
    check("bp_release_valid", data_valid, 0);

    // Asynchronous reset in the middle of a word
    set2(7, 4); send_beats(0, 0);
    check("pre_rst_onehot", onehot, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_onehot", onehot, 0);
    check("mid_rst_data_valid", data_valid, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_order_err", order_err, 0);
    check("mid_rst_code_ready", code_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set1(2); send_beats(1, 0);

    // Randomized words with random consumer stalls and input gaps
    rdy_mode = 1;
    for (int w = 0; w < 60; w++) begin
      bn = $urandom_range(1, 9);
      for (int i = 0; i < bn; i++) begin
        if (i > 0 && bcode[i-1] > 0 && $urandom_range(0, 9) < 8)
          bcode[i] = 3'($urandom_range(0, int'(bcode[i-1]) - 1));
        else
          bcode[i] = 3'($urandom_range(0, 7));
        bnone[i] = ($urandom_range(0, 19) == 0);
      end
      send_beats(1, 2);
    end

    // Drain
    rdy_mode = 0;
    waited = 0;
    while (exp_data_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    #1;
    nw = exp_data_q.size();
    check("scoreboard_drained", nw, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
